// File: rtl/softmax_exp_accum.sv
// Softmax exponential accumulator: collects NUM_CLASSES exponentials, forms a
// saturated sum for the reciprocal stage, then replays each exponential with
// the returned reciprocal to the normalising multiplier.
module softmax_exp_accum #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] rec_number,
  output logic                  rec_enable,
  input  logic                  rec_ack,
  input  logic [DATA_WIDTH-1:0] rec_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_exp,
  output logic [DATA_WIDTH-1:0] out_rec,
  output logic [IDX_WIDTH-1:0]  out_index,
  output logic                  out_last,
  output logic                  busy
);

  localparam int SUM_WIDTH = DATA_WIDTH + IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'b00,
    ST_REQ     = 2'b01,
    ST_DRAIN   = 2'b10
  } state_e;

  // Clamp the wide sum into the reciprocal operand width.
  function automatic logic [DATA_WIDTH-1:0] saturate(input logic [SUM_WIDTH-1:0] s);
    if (|s[SUM_WIDTH-1:DATA_WIDTH]) begin
      saturate = {DATA_WIDTH{1'b1}};
    end else begin
      saturate = s[DATA_WIDTH-1:0];
    end
  endfunction

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [SUM_WIDTH-1:0]  sum_q, sum_d;
  logic [DATA_WIDTH-1:0] rec_hold_q, rec_hold_d;
  logic [DATA_WIDTH-1:0] rec_number_q, rec_number_d;
  logic [DATA_WIDTH-1:0] buffer_q [NUM_CLASSES];
  logic                  in_ready_q, busy_q, rec_enable_q;
  logic                  out_valid_q, out_last_q;
  logic [DATA_WIDTH-1:0] out_exp_q, out_rec_q;
  logic [IDX_WIDTH-1:0]  out_index_q;

  logic                  in_fire_s;
  logic [SUM_WIDTH-1:0]  sum_next_s;
  logic [DATA_WIDTH-1:0] rd_exp_s;

  assign in_fire_s  = (state_q == ST_COLLECT) & in_valid;
  assign sum_next_s = sum_q + {{IDX_WIDTH{1'b0}}, in_data};

  // Next-state and datapath updates for the collect / request / drain sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    rec_hold_d   = rec_hold_q;
    rec_number_d = rec_number_q;
    case (state_q)
      ST_COLLECT: begin
        if (in_fire_s) begin
          sum_d = sum_next_s;
          if (cnt_q == LAST_IDX) begin
            rec_number_d = saturate(sum_next_s);
            if (sum_next_s == {SUM_WIDTH{1'b0}}) begin
              // Nothing to normalise by: skip the reciprocal request.
              state_d    = ST_DRAIN;
              rec_hold_d = {DATA_WIDTH{1'b1}};
            end else begin
              state_d = ST_REQ;
            end
          end else begin
            cnt_d = cnt_q + IDX_WIDTH'(1);
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_REQ: begin
        if (rec_ack) begin
          rec_hold_d = rec_result;
          state_d    = ST_DRAIN;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_COLLECT;
            cnt_d   = {IDX_WIDTH{1'b0}};
            idx_d   = {IDX_WIDTH{1'b0}};
            sum_d   = {SUM_WIDTH{1'b0}};
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        cnt_d   = {IDX_WIDTH{1'b0}};
        idx_d   = {IDX_WIDTH{1'b0}};
        sum_d   = {SUM_WIDTH{1'b0}};
      end
    endcase
  end

  // Replay read; forwards the element being written this cycle when it is the one selected.
  always_comb begin
    if (in_fire_s && (cnt_q == idx_d)) begin
      rd_exp_s = in_data;
    end else begin
      rd_exp_s = buffer_q[idx_d];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, sum, reciprocal hold and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= {IDX_WIDTH{1'b0}};
      idx_q        <= {IDX_WIDTH{1'b0}};
      sum_q        <= {SUM_WIDTH{1'b0}};
      rec_hold_q   <= {DATA_WIDTH{1'b0}};
      rec_number_q <= {DATA_WIDTH{1'b0}};
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      rec_enable_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_exp_q    <= {DATA_WIDTH{1'b0}};
      out_rec_q    <= {DATA_WIDTH{1'b0}};
      out_index_q  <= {IDX_WIDTH{1'b0}};
      out_last_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      rec_hold_q   <= rec_hold_d;
      rec_number_q <= rec_number_d;
      in_ready_q   <= (state_d == ST_COLLECT);
      busy_q       <= (state_d != ST_COLLECT);
      rec_enable_q <= (state_d == ST_REQ);
      out_valid_q  <= (state_d == ST_DRAIN);
      out_exp_q    <= (state_d == ST_DRAIN) ? rd_exp_s : {DATA_WIDTH{1'b0}};
      out_rec_q    <= (state_d == ST_DRAIN) ? rec_hold_d : {DATA_WIDTH{1'b0}};
      out_index_q  <= (state_d == ST_DRAIN) ? idx_d : {IDX_WIDTH{1'b0}};
      out_last_q   <= (state_d == ST_DRAIN) && (idx_d == LAST_IDX);
    end
  end

  // Exponential buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      buffer_q[cnt_q] <= in_data;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign rec_number = rec_number_q;
  assign rec_enable = rec_enable_q;
  assign out_valid  = out_valid_q;
  assign out_exp    = out_exp_q;
  assign out_rec    = out_rec_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_softmax_exp_accum.sv
// Self-checking bench for softmax_exp_accum: directed vectors plus randomized
// vectors with gapped input, random back-pressure and spurious acks, compared
// against a plain-arithmetic softmax-sum model.
module tb_softmax_exp_accum;
  localparam int DW = 8;
  localparam int N  = 10;
  localparam int IW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] rec_number;
  logic          rec_enable;
  logic          rec_ack;
  logic [DW-1:0] rec_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_exp;
  logic [DW-1:0] out_rec;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;

  softmax_exp_accum #(.DATA_WIDTH(DW), .NUM_CLASSES(N), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rec_number(rec_number), .rec_enable(rec_enable),
    .rec_ack(rec_ack), .rec_result(rec_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_exp(out_exp), .out_rec(out_rec),
    .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Stimulus vector and observations gathered by the stimulus tasks.
  logic [DW-1:0] vec [N];
  logic [DW-1:0] q_exp [$];
  logic [DW-1:0] q_rec [$];
  logic [IW-1:0] q_idx [$];
  logic          q_last [$];
  int            stall_bad, en_bad, ack_wait, drain_cycles;
  logic          saw_enable, en_after, val_after, rdy_end, busy_end;
  logic [DW-1:0] obs_rec_number;

  // Reference model results.
  int            m_sum;
  logic [DW-1:0] m_recnum, m_outrec;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Softmax-sum model: integer sum, clamp to 255, zero sum means reciprocal all-ones.
  task automatic model(input logic [DW-1:0] result);
    m_sum = 0;
    for (int i = 0; i < N; i++) m_sum += int'(vec[i]);
    m_recnum = (m_sum > 255) ? 8'hFF : 8'(m_sum);
    m_outrec = (m_sum == 0) ? 8'hFF : result;
  endtask

  task automatic send_range(input int lo, input int hi, input int gap_pct);
    int k;
    int guard;
    k = lo;
    guard = 0;
    while (k <= hi && guard < 1000) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = vec[k];
      end
      if (in_valid && in_ready) k++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    if (k <= hi) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: accepted %0d of %0d inputs", k - lo, hi - lo + 1);
    end
  endtask

  task automatic serve_rec(input int delay, input logic [DW-1:0] result);
    saw_enable = 1'b0; ack_wait = 0; en_bad = 0;
    while (!rec_enable && !out_valid && ack_wait < 50) begin
      tick();
      ack_wait++;
    end
    if (ack_wait >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: neither rec_enable nor out_valid after %0d cycles", ack_wait);
    end
    obs_rec_number = rec_number;
    if (rec_enable) begin
      saw_enable = 1'b1;
      for (int c = 0; c < delay; c++) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        tick();
        if (!rec_enable || rec_number !== obs_rec_number || in_ready || !busy || out_valid) en_bad++;
      end
      in_valid   = 1'b0;
      rec_ack    = 1'b1;
      rec_result = result;
      tick();
      rec_ack    = 1'b0;
      rec_result = 8'($urandom);
    end
    en_after  = rec_enable;
    val_after = out_valid;
  endtask

  task automatic drain(input int ready_pct, input bit ack_noise);
    logic [DW-1:0] e, r;
    logic [IW-1:0] ix;
    logic          l, fire, done;
    q_exp.delete(); q_rec.delete(); q_idx.delete(); q_last.delete();
    stall_bad = 0; drain_cycles = 0; done = 1'b0;
    while (!done && drain_cycles < 1000) begin
      out_ready = (int'($urandom_range(99)) < ready_pct);
      rec_ack   = ack_noise ? 1'($urandom_range(1)) : 1'b0;
      in_valid  = 1'($urandom_range(1));
      in_data   = 8'($urandom);
      if (!out_valid || in_ready || !busy) stall_bad++;
      e = out_exp; r = out_rec; ix = out_index; l = out_last;
      fire = out_valid && out_ready;
      tick();
      drain_cycles++;
      if (fire) begin
        q_exp.push_back(e); q_rec.push_back(r); q_idx.push_back(ix); q_last.push_back(l);
        if (l) done = 1'b1;
      end else if (out_exp !== e || out_rec !== r || out_index !== ix || out_last !== l) begin
        stall_bad++;
      end
    end
    out_ready = 1'b0; rec_ack = 1'b0; in_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d elements after %0d cycles", q_exp.size(), drain_cycles);
    end
    rdy_end  = in_ready;
    busy_end = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready, busy, rec_enable, out_valid, out_last} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got {rdy,busy,en,val,last}=%b expected 10000",
               {in_ready, busy, rec_enable, out_valid, out_last});
    end
    n_checks++;
    if (rec_number !== 8'h00 || out_exp !== 8'h00 || out_rec !== 8'h00 || out_index !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_data: rec_number=%0h out_exp=%0h out_rec=%0h out_index=%0d expected all 0",
               rec_number, out_exp, out_rec, out_index);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++) vec[i] = 8'(i + 1);
    model(8'h05);
    send_range(0, N - 1, 0);
    serve_rec(2, 8'h05);
    n_checks++;
    if (ack_wait !== 0 || saw_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_req_latency: wait=%0d saw_enable=%0b expected 0/1", ack_wait, saw_enable);
    end
    n_checks++;
    if (obs_rec_number !== m_recnum) begin
      n_fail++;
      $display("FAIL basic_rec_number: got %0d expected %0d", obs_rec_number, m_recnum);
    end
    n_checks++;
    if (en_bad !== 0 || en_after !== 1'b0 || val_after !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_req_phase: en_bad=%0d en_after=%0b val_after=%0b expected 0/0/1",
               en_bad, en_after, val_after);
    end
    drain(100, 1'b0);
    n_checks++;
    if (q_exp.size() !== N || drain_cycles !== N || stall_bad !== 0) begin
      n_fail++;
      $display("FAIL basic_drain_rate: outputs=%0d cycles=%0d bad=%0d expected %0d/%0d/0",
               q_exp.size(), drain_cycles, stall_bad, N, N);
    end
    for (int i = 0; i < q_exp.size(); i++) begin
      n_checks++;
      if (q_exp[i] !== vec[i] || q_rec[i] !== m_outrec || q_idx[i] !== 4'(i) || q_last[i] !== (i == N - 1)) begin
        n_fail++;
        $display("FAIL basic_out[%0d]: got exp=%0d rec=%0h idx=%0d last=%0b expected %0d/%0h/%0d/%0b",
                 i, q_exp[i], q_rec[i], q_idx[i], q_last[i], vec[i], m_outrec, i, (i == N - 1));
      end
    end
    n_checks++;
    if (rdy_end !== 1'b1 || busy_end !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_return: in_ready=%0b busy=%0b expected 1/0", rdy_end, busy_end);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < N; i++) vec[i] = 8'hFF;
    model(8'h01);
    send_range(0, N - 1, 0);
    serve_rec(1, 8'h01);
    n_checks++;
    if (obs_rec_number !== m_recnum) begin
      n_fail++;
      $display("FAIL sat_rec_number: got %0h expected %0h (sum %0d)", obs_rec_number, m_recnum, m_sum);
    end
    drain(100, 1'b0);
    for (int i = 0; i < q_exp.size(); i++) begin
      n_checks++;
      if (q_exp[i] !== vec[i] || q_rec[i] !== m_outrec || q_idx[i] !== 4'(i)) begin
        n_fail++;
        $display("FAIL sat_out[%0d]: got exp=%0h rec=%0h idx=%0d expected %0h/%0h/%0d",
                 i, q_exp[i], q_rec[i], q_idx[i], vec[i], m_outrec, i);
      end
    end
  endtask

  task automatic test_zero();
    for (int i = 0; i < N; i++) vec[i] = 8'h00;
    model(8'h33);
    send_range(0, N - 1, 0);
    serve_rec(1, 8'h33);
    n_checks++;
    if (saw_enable !== 1'b0 || val_after !== 1'b1 || ack_wait !== 0) begin
      n_fail++;
      $display("FAIL zero_skip_req: saw_enable=%0b out_valid=%0b wait=%0d expected 0/1/0",
               saw_enable, val_after, ack_wait);
    end
    drain(100, 1'b1);
    n_checks++;
    if (q_exp.size() !== N || stall_bad !== 0) begin
      n_fail++;
      $display("FAIL zero_count: got %0d outputs bad=%0d expected %0d/0", q_exp.size(), stall_bad, N);
    end
    for (int i = 0; i < q_exp.size(); i++) begin
      n_checks++;
      if (q_exp[i] !== 8'h00 || q_rec[i] !== m_outrec || q_last[i] !== (i == N - 1)) begin
        n_fail++;
        $display("FAIL zero_out[%0d]: got exp=%0h rec=%0h last=%0b expected 00/%0h/%0b",
                 i, q_exp[i], q_rec[i], q_last[i], m_outrec, (i == N - 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] res;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) vec[i] = (v % 2 == 0) ? 8'($urandom_range(40)) : 8'($urandom);
      res = 8'($urandom);
      model(res);
      send_range(0, N - 1, 30);
      serve_rec(int'($urandom_range(4)), res);
      n_checks++;
      if (obs_rec_number !== m_recnum || en_bad !== 0 || en_after !== 1'b0 || val_after !== 1'b1) begin
        n_fail++;
        $display("FAIL rand%0d_req: rec_number=%0h en_bad=%0d en_after=%0b val=%0b expected %0h/0/0/1",
                 v, obs_rec_number, en_bad, en_after, val_after, m_recnum);
      end
      drain(50, 1'b1);
      n_checks++;
      if (q_exp.size() !== N || stall_bad !== 0 || rdy_end !== 1'b1 || busy_end !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_drain: outputs=%0d stall_bad=%0d rdy=%0b busy=%0b expected %0d/0/1/0",
                 v, q_exp.size(), stall_bad, rdy_end, busy_end, N);
      end
      for (int i = 0; i < q_exp.size(); i++) begin
        n_checks++;
        if (q_exp[i] !== vec[i] || q_rec[i] !== m_outrec || q_idx[i] !== 4'(i) || q_last[i] !== (i == N - 1)) begin
          n_fail++;
          $display("FAIL rand%0d_out[%0d]: got exp=%0h rec=%0h idx=%0d last=%0b expected %0h/%0h/%0d/%0b",
                   v, i, q_exp[i], q_rec[i], q_idx[i], q_last[i], vec[i], m_outrec, i, (i == N - 1));
        end
      end
    end
  endtask

  task automatic test_ack_in_collect();
    for (int i = 0; i < N; i++) vec[i] = 8'($urandom_range(20));
    model(8'h11);
    send_range(0, 3, 0);
    rec_ack = 1'b1;
    rec_result = 8'hAA;
    tick();
    tick();
    rec_ack = 1'b0;
    n_checks++;
    if ({in_ready, busy, rec_enable, out_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL ack_collect_state: got {rdy,busy,en,val}=%b expected 1000",
               {in_ready, busy, rec_enable, out_valid});
    end
    send_range(4, N - 1, 0);
    serve_rec(1, 8'h11);
    n_checks++;
    if (obs_rec_number !== m_recnum || saw_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_collect_sum: rec_number=%0h saw_enable=%0b expected %0h/1",
               obs_rec_number, saw_enable, m_recnum);
    end
    drain(100, 1'b0);
    n_checks++;
    if (q_exp.size() !== N || q_rec[0] !== m_outrec || q_exp[N-1] !== vec[N-1]) begin
      n_fail++;
      $display("FAIL ack_collect_out: outputs=%0d rec=%0h last_exp=%0h expected %0d/%0h/%0h",
               q_exp.size(), q_rec[0], q_exp[N-1], N, m_outrec, vec[N-1]);
    end
  endtask

  task automatic test_reset_mid_req();
    for (int i = 0; i < N; i++) vec[i] = 8'($urandom);
    vec[0] = 8'h80;
    send_range(0, N - 1, 20);
    tick();
    n_checks++;
    if (rec_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL midreq_enable: rec_enable=%0b expected 1", rec_enable);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({rec_enable, in_ready, busy, out_valid} !== 4'b0100) begin
      n_fail++;
      $display("FAIL midreq_reset: got {en,rdy,busy,val}=%b expected 0100",
               {rec_enable, in_ready, busy, out_valid});
    end
    for (int i = 0; i < N; i++) vec[i] = 8'($urandom_range(25));
    model(8'h42);
    send_range(0, N - 1, 0);
    serve_rec(0, 8'h42);
    n_checks++;
    if (obs_rec_number !== m_recnum) begin
      n_fail++;
      $display("FAIL midreq_clean_sum: got %0d expected %0d", obs_rec_number, m_recnum);
    end
    drain(70, 1'b0);
    for (int i = 0; i < q_exp.size(); i++) begin
      n_checks++;
      if (q_exp[i] !== vec[i] || q_rec[i] !== m_outrec || q_idx[i] !== 4'(i)) begin
        n_fail++;
        $display("FAIL midreq_out[%0d]: got exp=%0h rec=%0h idx=%0d expected %0h/%0h/%0d",
                 i, q_exp[i], q_rec[i], q_idx[i], vec[i], m_outrec, i);
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    rec_ack    = 1'b0;
    rec_result = 8'h00;
    out_ready  = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_zero();
    test_back_to_back();
    test_ack_in_collect();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/softmax_exp_accum.md
SOFTMAX_EXP_ACCUM -- requirements
Module: softmax_exp_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of exponential values and reciprocal operands.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, number of exponential values per softmax vector.
REQ-003 SHALL have parameter IDX_WIDTH, default 4, index width, with 2^IDX_WIDTH >= NUM_CLASSES.
REQ-004 SHALL use one clock and a synchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, synchronous active-low reset).
REQ-005 SHALL have in_valid (input, 1): upstream exponential value present.
REQ-006 SHALL have in_ready (output, 1): block accepts in_data.
REQ-007 SHALL have in_data (input, DATA_WIDTH): unsigned exponential value.
REQ-008 SHALL have rec_number (output, DATA_WIDTH): saturated sum fed to the reciprocal stage.
REQ-009 SHALL have rec_enable (output, 1): reciprocal request, held while waiting.
REQ-010 SHALL have rec_ack (input, 1): reciprocal stage done.
REQ-011 SHALL have rec_result (input, DATA_WIDTH): 1/sum from the reciprocal stage.
REQ-012 SHALL have out_valid (output, 1), out_ready (input, 1), out_exp (output, DATA_WIDTH), out_rec (output, DATA_WIDTH), out_index (output, IDX_WIDTH) and out_last (output, 1): the replay stream to the normalising multiplier.
REQ-013 SHALL have busy (output, 1): high in any state other than COLLECT.

Function
REQ-014 SHALL implement states COLLECT, REQ, DRAIN.
REQ-015 COLLECT: in_ready=1; a transfer occurs on in_valid&in_ready at a rising edge, stores in_data in buffer[cnt], adds it to sum (DATA_WIDTH+IDX_WIDTH bits, no overflow possible), and increments cnt.
REQ-016 The transfer with cnt==NUM_CLASSES-1 SHALL move to REQ, or to DRAIN if the final sum is 0; in_ready SHALL be 0 from the next cycle.
REQ-017 rec_number SHALL be all-ones if sum >= 2^DATA_WIDTH, else sum[DATA_WIDTH-1:0]; it is registered and stable throughout REQ.
REQ-018 REQ: rec_enable=1 from the first REQ cycle; on the first rising edge sampling rec_ack=1, the block latches rec_result into rec_hold, drops rec_enable the next cycle, and enters DRAIN.
REQ-019 rec_ack sampled high during COLLECT or DRAIN SHALL be ignored.
REQ-020 A zero sum SHALL skip REQ: rec_enable stays 0 and rec_hold is set to all-ones.
REQ-021 DRAIN: out_valid=1; out_exp=buffer[idx], out_rec=rec_hold, out_index=idx, out_last=(idx==NUM_CLASSES-1); the outputs are stable while out_valid&!out_ready.
REQ-022 Each out_valid&out_ready edge SHALL increment idx; the transfer with out_last=1 returns to COLLECT with cnt, idx and sum cleared, and in_ready=1 the next cycle.
REQ-023 Latency: REQ is entered 1 cycle after the last input; DRAIN is entered 1 cycle after rec_ack is sampled; with out_ready held at 1 there is 1 output per cycle.
REQ-024 No input SHALL be accepted outside COLLECT; back-pressure is via in_ready only.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force COLLECT and set cnt=idx=sum=0, rec_hold=0, rec_number=0, rec_enable=0, out_valid=0, out_last=0, out_exp=0, out_rec=0, out_index=0, busy=0, in_ready=1 from the first cycle after reset.
REQ-026 Reset in any state, including mid-REQ with rec_enable=1, SHALL abort the vector; buffer contents need not be cleared.

Verification
REQ-027 Inputs 1..10 back-to-back, rec_ack returned 3 cycles after rec_enable with rec_result=0x05, out_ready=1 -> rec_number=55, then 10 outputs with out_exp=1..10, out_rec=0x05, out_index=0..9, out_last only on index 9.
REQ-028 Ten inputs of 0xFF -> sum 2550 and rec_number=0xFF (saturated).
REQ-029 Ten inputs of 0 -> rec_enable never asserted, DRAIN entered directly, out_rec=0xFF.
REQ-030 out_ready toggled randomly and in_valid gapped -> no duplicated or dropped elements, outputs stable while stalled, in_ready=0 throughout REQ and DRAIN.
REQ-031 rst_n=0 while rec_enable=1 -> next cycle rec_enable=0, in_ready=1, busy=0; a following clean vector produces the correct sum.
REQ-032 rec_ack=1 pulsed during COLLECT -> ignored, with no state change.
